// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
// Imported by the cpu side so both agree on widths.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, registered read.
// Contents are not reset.
module mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write on we, otherwise register the read word
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with burst lock
// and lock timeout in front of the data memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              lock_err
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(MAX_LOCK - 1);

  arb_state_e       state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;

  logic              xfer0, xfer1;
  logic              m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [DATA_W-1:0] hold0, hold1;

  // grant decode from state, requests and pointer
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        unique case (1'b1)
          (req0 && req1): begin
            gnt0 = (rr_q == PORT_CPU);
            gnt1 = (rr_q == PORT_LDR);
          end
          default: begin
            gnt0 = req0;
            gnt1 = req1;
          end
        endcase
      end
      ST_LOCK0: gnt0 = req0;
      ST_LOCK1: gnt1 = req1;
      default: ;
    endcase
  end

  assign xfer0 = req0 & gnt0;
  assign xfer1 = req1 & gnt1;

  // a write seen while reset is low must not land
  assign m_en    = (xfer0 | xfer1) & reset_n;
  assign m_we    = xfer1 ? we1 : we0;
  assign m_addr  = xfer1 ? addr1 : addr0;
  assign m_wdata = xfer1 ? wdata1 : wdata0;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .en    (m_en),
    .we    (m_we),
    .addr  (m_addr),
    .wdata (m_wdata),
    .rdata (m_rdata)
  );

  // next state, pointer, lock counter, timeout pulse
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (xfer0) begin
          rr_d = PORT_LDR;
          if (lock0) begin
            state_d = ST_LOCK0;
            cnt_d   = '0;
          end
        end else if (xfer1) begin
          rr_d = PORT_CPU;
          if (lock1) begin
            state_d = ST_LOCK1;
            cnt_d   = '0;
          end
        end
      end
      ST_LOCK0: begin
        cnt_d = cnt_q + 1'b1;
        if (xfer0) rr_d = PORT_LDR;
        if (xfer0 && !lock0) begin
          state_d = ST_ARB;
        end else if (cnt_q == LAST) begin
          state_d = ST_ARB;
          rr_d    = PORT_LDR;
          err_d   = 1'b1;
        end
      end
      ST_LOCK1: begin
        cnt_d = cnt_q + 1'b1;
        if (xfer1) rr_d = PORT_CPU;
        if (xfer1 && !lock1) begin
          state_d = ST_ARB;
        end else if (cnt_q == LAST) begin
          state_d = ST_ARB;
          rr_d    = PORT_CPU;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // arbitration state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ARB;
      rr_q     <= PORT_CPU;
      cnt_q    <= '0;
      lock_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      lock_err <= err_d;
    end
  end

  // read-valid flags and per-port data hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      hold0   <= '0;
      hold1   <= '0;
    end else begin
      rvalid0 <= xfer0 & ~we0;
      rvalid1 <= xfer1 & ~we1;
      if (rvalid0) hold0 <= m_rdata;
      if (rvalid1) hold1 <= m_rdata;
    end
  end

  assign rdata0 = rvalid0 ? m_rdata : hold0;
  assign rdata1 = rvalid1 ? m_rdata : hold1;

endmodule
